hamming_dma_engine: RTL
=======================

# hamming_dma_engine

Hardware replacement for the software Hamming programs: a memory-mapped SECDED engine that walks a block of messages in the processor's byte-wide data memory. In encode mode it packs 11-bit messages into 16-bit codewords. In decode mode it corrects single-bit errors, flags double-bit errors and unpacks the data. It sits beside the processor on the data-memory port, is launched by the same `start` pulse and signals completion on `done`.

## Interface
- `NUM_MSG`, 15: messages per run, 1..127.
- `ADDR_W`, 8: data-memory address width.
- `SRC_BASE`, 0: byte address of the first input message.
- `DST_BASE`, 30: byte address of the first output message.
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle launch pulse, sampled only in IDLE or DONE.
- `mode` input 1: 0 = encode, 1 = decode; latched on the accepted `start`.
- `mem_addr` output ADDR_W: byte address.
- `mem_rdata` input 8: combinational read data for `mem_addr`.
- `mem_wdata` output 8: write data.
- `mem_we` output 1: write strobe, one byte per cycle.
- `busy` output 1: high from the cycle after an accepted `start` until DONE.
- `done` output 1: high in DONE, held until the next accepted `start` or `Reset`.
- `n_single` output 8: count of corrected single errors in the last decode run, saturating at 255.
- `n_double` output 8: count of detected double errors in the last decode run, saturating at 255.

## Operation
- Message i, with i running 0..NUM_MSG-1, uses lo byte at base+2i and hi byte at base+2i+1.
- Encode input: lo = d[8:1], hi = {5'b0, d[11:9]}. Upper 5 bits are ignored.
- Encode output: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = even parity over all 15 other bits.
- Decode input is a 16-bit codeword; bit position k carries weight k.
  - syndrome s = XOR of the indices of all set bits in [15:1].
  - q = ^codeword.
- Decode outcomes:
  - s==0, q==0: clean; flags 2'b00.
  - q==1: single error at position s; invert that bit (s==0 means p0 only); flags 2'b01; `n_single`++.
  - s!=0, q==0: double error, data not corrected; flags 2'b10; `n_double`++.
- Decode output: lo = d[8:1], hi = {flags, 3'b0, d[11:9]}.
- FSM states and transitions:
  - IDLE -> RD_LO on start.
  - RD_LO -> RD_HI: capture lo byte.
  - RD_HI -> CALC: capture hi byte.
  - CALC -> WR_LO: register the result.
  - WR_LO -> WR_HI.
  - WR_HI -> RD_LO, or -> DONE after the last message.
  - DONE -> RD_LO on start.
- An accepted `start` clears both counters and the message index.
- `start` while busy is ignored; `mode` changes mid-run are ignored.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- Overlapping source and destination regions are allowed. Each message is fully read before it is written.

## Timing
- Reset values: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `busy`=0, `done`=0, counters=0, state IDLE.
- `Reset` mid-run returns to IDLE next edge. No further writes occur; bytes already written stay written.
- Each message takes 5 cycles. `mem_we` is high only in WR_LO and WR_HI.
- `start` accepted at edge t: `busy` rises at t+1, `done` rises at t+1+5·NUM_MSG, with `busy` falling in the same cycle.
- `Reset` and `start` in the same cycle: `Reset` wins.

## Structure
- Package `hamming_pkg` holds:
  - state enum
  - mode enum (ENC, DEC)
  - flag constants (FL_OK, FL_SGL, FL_DBL)
  - pure functions `ham_encode(d11)` and `ham_syndrome(cw16)`
- Sub-module `hamming_secded`: purely combinational core (mode, 16-bit in -> 16-bit out, flags). It is instantiated once and shared by both modes.

## Test plan
- Encode d=11'h000, 11'h7FF, 11'h001 -> output words 16'h0000, 16'hFFFF, 16'h000F. `done` asserts exactly 1+5·NUM_MSG cycles after `start`.
- Decode 16'h008F (bit 7 flipped) -> lo 8'h01, hi 8'h40; `n_single`=1.
- Decode 16'h800E (bits 15 and 0 flipped) -> lo 8'h01, hi 8'h84; `n_double`=1.
- Decode 16'h000E (p0 flipped) -> lo 8'h01, hi 8'h40. Decode 16'hFFFF -> lo 8'hFF, hi 8'h07.
- 15 random messages in encode mode, then the engine's own output fed back in decode mode with one random bit flipped per word -> all 15 recovered, `n_single`=15, `n_double`=0.
- `Reset` asserted during WR_LO of message 3 -> next cycle `mem_we`=0, `busy`=0, `done`=0; message 3's hi byte is unwritten; a fresh `start` completes the full run correctly.

Source files
------------

// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared types and pure helper functions for the Hamming SECDED DMA engine.
//   state_e      : engine FSM states
//   mode_e       : ENC (pack 11-bit data) / DEC (correct, flag, unpack)
//   FL_*         : decode outcome flags placed in bits [7:6] of the hi byte
//   ham_encode   : 11-bit data -> 16-bit SECDED codeword
//   ham_syndrome : XOR of the indices of all set bits in cw[15:1]
// -----------------------------------------------------------------------------
package hamming_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_CALC  = 3'd3,
        ST_WR_LO = 3'd4,
        ST_WR_HI = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } mode_e;

    localparam logic [1:0] FL_OK  = 2'b00;
    localparam logic [1:0] FL_SGL = 2'b01;
    localparam logic [1:0] FL_DBL = 2'b10;

    // d11[0] is d1 ... d11[10] is d11. Parity bits sit at the power-of-two
    // positions; bit 0 is overall even parity of bits [15:1].
    function automatic logic [15:0] ham_encode(input logic [10:0] d11);
        logic [15:0] cw;
        logic        p8;
        logic        p4;
        logic        p2;
        logic        p1;
        p8 = ^d11[10:4];
        p4 = (^d11[10:7]) ^ (^d11[3:1]);
        p2 = d11[10] ^ d11[9] ^ d11[6] ^ d11[5] ^ d11[3] ^ d11[2] ^ d11[0];
        p1 = d11[10] ^ d11[8] ^ d11[6] ^ d11[4] ^ d11[3] ^ d11[1] ^ d11[0];
        cw = {d11[10:4], p8, d11[3:1], p4, d11[0], p2, p1, 1'b0};
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [3:0] ham_syndrome(input logic [15:0] cw16);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw16[k]) begin
                s = s ^ 4'(k);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming_secded.sv
// -----------------------------------------------------------------------------
// hamming_secded
// Purely combinational SECDED core shared by both engine modes.
// Ports:
//   i_mode  : ENC or DEC
//   i_word  : {hi, lo} bytes as read from memory
//   o_word  : {hi, lo} bytes to write back
//   o_flags : decode outcome (FL_OK in encode mode)
// -----------------------------------------------------------------------------
module hamming_secded
    import hamming_pkg::*;
(
    input  mode_e       i_mode,
    input  logic [15:0] i_word,
    output logic [15:0] o_word,
    output logic [1:0]  o_flags
);

    logic [3:0]  w_syn;
    logic        w_par;
    logic [15:0] w_fixed;
    logic [10:0] w_data;

    assign w_syn = ham_syndrome(i_word);
    assign w_par = ^i_word;

    // Encode packs the 11 data bits; decode corrects/flags and unpacks.
    always_comb begin
        w_fixed = i_word;
        w_data  = 11'h000;
        o_word  = 16'h0000;
        o_flags = FL_OK;
        if (i_mode == ENC) begin
            // Upper five bits of the hi byte are don't-care on input.
            o_word  = ham_encode({i_word[10:8], i_word[7:0]});
            o_flags = FL_OK;
        end else begin
            if (w_par) begin
                // Odd overall parity: single error at position s (s==0 is p0).
                w_fixed = i_word ^ (16'h0001 << w_syn);
                o_flags = FL_SGL;
            end else if (w_syn != 4'd0) begin
                // Even parity but nonzero syndrome: two bits flipped, leave as is.
                w_fixed = i_word;
                o_flags = FL_DBL;
            end else begin
                w_fixed = i_word;
                o_flags = FL_OK;
            end
            w_data = {w_fixed[15:9], w_fixed[7:5], w_fixed[3]};
            o_word = {o_flags, 3'b000, w_data[10:8], w_data[7:0]};
        end
    end

endmodule

// File: rtl/hamming_dma_engine.sv
// -----------------------------------------------------------------------------
// hamming_dma_engine
// Walks NUM_MSG two-byte messages in byte-wide data memory, encoding 11-bit
// data into SECDED codewords or decoding codewords back to data with flags.
// Ports:
//   CLK, Reset      : clock and synchronous active-high reset
//   start, mode     : launch pulse (IDLE/DONE only) and mode latched with it
//   mem_addr        : byte address (registered)
//   mem_rdata       : combinational read data for mem_addr
//   mem_wdata/we    : one-byte write per cycle in WR_LO / WR_HI
//   busy, done      : run in progress / run finished (held until next start)
//   n_single/double : saturating error counters of the last decode run
// Registered outputs are loaded from the next state so they line up with the
// state they describe: mem_addr is valid in RD_LO/RD_HI for the capture.
// -----------------------------------------------------------------------------
module hamming_dma_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int ADDR_W   = 8,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [7:0]        n_single,
    output logic [7:0]        n_double
);

    localparam logic [6:0]        LAST_IDX = 7'(NUM_MSG - 1);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(32'd1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [6:0]        r_idx;
    logic [6:0]        w_idx_nxt;
    mode_e             r_mode;
    logic [7:0]        r_lo;
    logic [7:0]        r_hi;
    logic [7:0]        r_res_hi;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_off;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        w_wdata_nxt;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_n_single;
    logic [7:0]        r_n_double;
    logic              w_start_ok;
    logic [15:0]       w_core_word;
    logic [1:0]        w_core_flags;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    hamming_secded u_secded (
        .i_mode  (r_mode),
        .i_word  ({r_hi, r_lo}),
        .o_word  (w_core_word),
        .o_flags (w_core_flags)
    );

    // Next-state and message-index logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_RD_LO;
                    w_idx_nxt   = 7'd0;
                end else begin
                    w_state_nxt = r_state;
                    w_idx_nxt   = r_idx;
                end
            end
            ST_RD_LO: w_state_nxt = ST_RD_HI;
            ST_RD_HI: w_state_nxt = ST_CALC;
            ST_CALC:  w_state_nxt = ST_WR_LO;
            ST_WR_LO: w_state_nxt = ST_WR_HI;
            ST_WR_HI: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RD_LO;
                    w_idx_nxt   = r_idx + 7'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 7'd0;
            end
        endcase
    end

    // Bus address and write data for the upcoming state; address wraps modulo 2^ADDR_W.
    always_comb begin
        w_off       = ADDR_W'({w_idx_nxt, 1'b0});
        w_addr_nxt  = {ADDR_W{1'b0}};
        w_wdata_nxt = 8'h00;
        case (w_state_nxt)
            ST_RD_LO: w_addr_nxt = SRC_A + w_off;
            ST_RD_HI: w_addr_nxt = SRC_A + w_off + ONE_A;
            ST_CALC:  w_addr_nxt = r_mem_addr;
            ST_WR_LO: begin
                w_addr_nxt  = DST_A + w_off;
                w_wdata_nxt = w_core_word[7:0];
            end
            ST_WR_HI: begin
                w_addr_nxt  = DST_A + w_off + ONE_A;
                w_wdata_nxt = r_res_hi;
            end
            default: begin
                w_addr_nxt  = {ADDR_W{1'b0}};
                w_wdata_nxt = 8'h00;
            end
        endcase
    end

    // State register and registered bus/status outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 7'd0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= 8'h00;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_mem_we    <= (w_state_nxt == ST_WR_LO) || (w_state_nxt == ST_WR_HI);
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    // Mode latch, byte capture, result hi byte and saturating error counters.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_mode     <= ENC;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_res_hi   <= 8'h00;
            r_n_single <= 8'h00;
            r_n_double <= 8'h00;
        end else begin
            if (w_start_ok) begin
                r_mode     <= mode_e'(mode);
                r_n_single <= 8'h00;
                r_n_double <= 8'h00;
            end else if ((r_state == ST_CALC) && (r_mode == DEC)) begin
                if ((w_core_flags == FL_SGL) && (r_n_single != 8'hFF)) begin
                    r_n_single <= r_n_single + 8'd1;
                end
                if ((w_core_flags == FL_DBL) && (r_n_double != 8'hFF)) begin
                    r_n_double <= r_n_double + 8'd1;
                end
            end
            if (r_state == ST_RD_LO) begin
                r_lo <= mem_rdata;
            end
            if (r_state == ST_RD_HI) begin
                r_hi <= mem_rdata;
            end
            if (r_state == ST_CALC) begin
                r_res_hi <= w_core_word[15:8];
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign n_single  = r_n_single;
    assign n_double  = r_n_double;

endmodule
